// File: rtl/sample_frame_buffer.sv
// Ping-pong sample frame buffer: fills one bank while the FFT reads the other.
// Optional macro SAMPLE_OVERRUN_CNT_EN adds a saturating 8-bit dropped-frame counter.
//
// state   | meaning
// IDLE    | capture disabled, write pointer parked at 0
// FILL    | writing valid samples into the write bank
// HANDOFF | frame complete; hand bank to reader or drop it as an overrun
module sample_frame_buffer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                           sample_valid_i,
    input  logic                           enable_i,
    input  logic        [ADDR_WIDTH-1:0]   address_i,
    output logic        [SAMPLE_WIDTH-1:0] data_o,
    output logic                           start_o,
    input  logic                           release_i,
    output logic                           overrun_o,
    output logic        [7:0]              overrun_cnt_o
);

    localparam int MEM_WORDS = 2 ** (ADDR_WIDTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    wbank, wbank_nxt;
    logic                    rd_busy, rd_busy_nxt;
    logic                    busy_eff;
    logic                    handoff_ok;
    logic                    handoff_drop;
    logic                    wr_en;

    logic [SAMPLE_WIDTH-1:0] mem [MEM_WORDS];

    // A release in the decision cycle frees the reader before the decision is made.
    assign busy_eff     = rd_busy & ~release_i;
    assign handoff_ok   = (state == HANDOFF) && !busy_eff;
    assign handoff_drop = (state == HANDOFF) && busy_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            wbank   <= 1'b0;
            rd_busy <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            wbank   <= wbank_nxt;
            rd_busy <= rd_busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i) state_nxt = FILL;
            FILL: begin
                if (!enable_i)
                    state_nxt = IDLE;
                else if (sample_valid_i && (wr_ptr == LAST_ADDR))
                    state_nxt = HANDOFF;
            end
            HANDOFF: state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_o     = handoff_ok;
        wbank_nxt   = wbank ^ handoff_ok;
        rd_busy_nxt = handoff_ok | busy_eff;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr;
        wr_ptr_nxt  = wr_ptr;
        case (state)
            IDLE: wr_ptr_nxt = '0;
            FILL: begin
                if (!enable_i) begin
                    wr_ptr_nxt = '0;
                end else if (sample_valid_i) begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                end
            end
            HANDOFF: begin
                // The next frame starts immediately, at address 0 of the post-decision bank.
                wr_addr    = '0;
                wr_en      = sample_valid_i;
                wr_ptr_nxt = sample_valid_i ? ADDR_WIDTH'(1) : '0;
            end
            default: wr_ptr_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wbank_nxt, wr_addr}] <= sample_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_o <= '0;
        else
            data_o <= mem[{~wbank, address_i}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_o <= 1'b0;
        else if (handoff_drop)
            overrun_o <= 1'b1;
    end

`ifdef SAMPLE_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_cnt_o <= '0;
        else if (handoff_drop && (overrun_cnt_o != 8'hFF))
            overrun_cnt_o <= overrun_cnt_o + 8'd1;
    end
`else
    assign overrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Randomized bench for sample_frame_buffer against a frame-level reference model;
// a second, tiny-frame instance exercises overrun counter saturation.
module tb_sample_frame_buffer;

`ifdef SAMPLE_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int N = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample = '0;
    logic        valid = 1'b0, enable = 1'b0, rel = 1'b0;
    logic [9:0]  addr = '0;
    logic [15:0] data_o;
    logic        start_o, overrun_o;
    logic [7:0]  overrun_cnt_o;

    logic        sm_rst_n = 1'b0;
    logic [15:0] sm_sample = '0;
    logic        sm_valid = 1'b0, sm_enable = 1'b0, sm_rel = 1'b0;
    logic [1:0]  sm_addr = '0;
    logic [15:0] sm_data;
    logic        sm_start, sm_ovr;
    logic [7:0]  sm_cnt;

    always #5 clk = ~clk;

    sample_frame_buffer #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .sample_i(sample), .sample_valid_i(valid),
        .enable_i(enable), .address_i(addr), .data_o(data_o), .start_o(start_o),
        .release_i(rel), .overrun_o(overrun_o), .overrun_cnt_o(overrun_cnt_o));

    sample_frame_buffer #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(sm_rst_n), .sample_i(sm_sample), .sample_valid_i(sm_valid),
        .enable_i(sm_enable), .address_i(sm_addr), .data_o(sm_data), .start_o(sm_start),
        .release_i(sm_rel), .overrun_o(sm_ovr), .overrun_cnt_o(sm_cnt));

    int n_checks = 0;
    int n_pass   = 0;
    int n_start  = 0;
    int sm_nstart = 0;

    // Reference model: frame-level view of capture, bank ownership and overruns.
    logic [15:0] m_mem [2][N];
    bit          m_ok  [2][N];
    bit          m_active, m_pending, m_wb, m_busy, m_ovr, m_wrote;
    int          m_count, m_ocnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 0; m_pending = 0; m_wb = 0; m_busy = 0; m_ovr = 0;
        m_count = 0; m_ocnt = 0; m_wrote = 0;
    endtask

    task automatic model_write(input int a, input logic [15:0] s);
        m_mem[int'(m_wb)][a] = s;
        m_ok[int'(m_wb)][a]  = 1'b1;
        m_wrote = 1;
    endtask

    // One clock cycle: drive inputs, advance the model, check combinational then registered outputs.
    task automatic cyc(input bit en_t, input bit v_t, input bit rel_t,
                       input logic [15:0] s_t, input logic [9:0] a_t);
        bit          exp_start, have_data;
        logic [15:0] exp_data;
        @(negedge clk);
        enable = en_t; valid = v_t; rel = rel_t; sample = s_t; addr = a_t;
        have_data = m_ok[int'(!m_wb)][int'(a_t)];
        exp_data  = m_mem[int'(!m_wb)][int'(a_t)];
        exp_start = 0;
        m_wrote   = 0;
        if (rel_t) m_busy = 0;
        if (m_pending) begin
            m_pending = 0;
            if (!m_busy) begin
                m_wb = !m_wb; m_busy = 1; exp_start = 1;
            end else begin
                m_ovr = 1;
                if (m_ocnt < 255) m_ocnt++;
            end
            m_count = 0;
            if (v_t) begin model_write(0, s_t); m_count = 1; end
        end else if (m_active) begin
            if (!en_t) begin
                m_active = 0; m_count = 0;
            end else if (v_t) begin
                model_write(m_count, s_t);
                m_count++;
                if (m_count == N) begin m_pending = 1; m_count = 0; end
            end
        end else if (en_t) begin
            m_active = 1;
        end
        #1;
        check("start_o", {31'd0, start_o}, {31'd0, exp_start});
        if (start_o) n_start++;
        @(posedge clk);
        #1;
        if (have_data) check("data_o", {16'd0, data_o}, {16'd0, exp_data});
        check("overrun_o", {31'd0, overrun_o}, {31'd0, m_ovr});
        check("overrun_cnt_o", {24'd0, overrun_cnt_o}, CNT_EN ? m_ocnt : 0);
    endtask

    // Feed until n samples were accepted; rel_mode 0 none, 1 in decision cycle, 2 random.
    task automatic feed(input int n, input int rel_mode, input bit kval);
        int   w = 0, guard = 0;
        bit   v_t, r_t;
        logic [15:0] s_t;
        while (w < n && guard < 20 * n + 100) begin
            v_t = ($urandom % 4) != 0;
            r_t = (rel_mode == 1) ? m_pending : (rel_mode == 2) ? (($urandom % 64) == 0) : 1'b0;
            s_t = kval ? 16'(m_count) : 16'($urandom);
            cyc(1, v_t, r_t, s_t, 10'($urandom));
            w += int'(m_wrote);
            guard++;
        end
        if (w < n) check("feed_timeout", w, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; enable = 0; valid = 0; rel = 0;
        #1;
        check("rst_start_o", {31'd0, start_o}, 0);
        check("rst_data_o", {16'd0, data_o}, 0);
        check("rst_overrun_o", {31'd0, overrun_o}, 0);
        check("rst_overrun_cnt", {24'd0, overrun_cnt_o}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    always @(negedge clk) if (sm_rst_n && sm_start) sm_nstart++;

    initial begin
        int s0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++) begin m_ok[b][a] = 0; m_mem[b][a] = '0; end
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Frame 1: value k at index k, handed to the reader.
        cyc(1, 0, 0, 0, 0);
        feed(N, 0, 1);
        cyc(1, 0, 0, 0, 10'd5);
        cyc(1, 0, 0, 0, 10'd5);
        check("frame1_starts", n_start, 1);
        check("frame1_rd5", {16'd0, data_o}, 5);

        // Frame 2: reader still busy, frame dropped.
        feed(N, 0, 0);
        cyc(1, 0, 0, 0, 10'd5);
        cyc(1, 0, 0, 0, 10'd5);
        check("frame2_starts", n_start, 1);
        check("frame2_overrun", {31'd0, overrun_o}, 1);
        check("frame2_cnt", {24'd0, overrun_cnt_o}, CNT_EN ? 1 : 0);
        check("frame2_rd5", {16'd0, data_o}, 5);

        // Frame 3: release coincides with the decision cycle.
        feed(N, 1, 0);
        cyc(1, 0, 1, 0, 10'd5);
        cyc(1, 0, 0, 0, 10'd5);
        check("frame3_starts", n_start, 2);
        check("frame3_cnt", {24'd0, overrun_cnt_o}, CNT_EN ? 1 : 0);
        check("frame3_bank", {16'd0, data_o}, {16'd0, m_mem[1][5]});

        // Reset mid-frame discards the partial frame.
        cyc(1, 0, 1, 0, 0);
        feed(500, 2, 0);
        do_reset();
        s0 = n_start;
        feed(N - 1, 2, 0);
        check("rst_no_early_start", n_start, s0);
        feed(1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("rst_full_frame_start", n_start, s0 + 1);

        // Enable drop discards the partial frame.
        feed(300, 0, 0);
        repeat (3) cyc(0, 1, 0, 16'($urandom), 10'($urandom));
        cyc(0, 0, 1, 0, 0);
        s0 = n_start;
        feed(N - 1, 0, 0);
        check("en_no_early_start", n_start, s0);
        feed(1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("en_full_frame_start", n_start, s0 + 1);

        // Back-to-back 4-sample frames: one handoff then 300+ overruns.
        @(negedge clk);
        sm_rst_n = 1; sm_enable = 1;
        @(negedge clk);
        sm_valid = 1;
        for (int i = 0; i < 1220; i++) begin
            sm_sample = 16'($urandom);
            sm_addr   = 2'($urandom);
            @(negedge clk);
        end
        check("sat_starts", sm_nstart, 1);
        check("sat_overrun", {31'd0, sm_ovr}, 1);
        check("sat_cnt", {24'd0, sm_cnt}, CNT_EN ? 255 : 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_frame_buffer.md
SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, meaning the sample word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the log2 of the frame length (1024 samples).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sample_i, input, SAMPLE_WIDTH bits: signed audio sample from the acquisition side.
REQ-006 SHALL have port sample_valid_i, input, 1 bit: one-cycle qualifier for sample_i.
REQ-007 SHALL have port enable_i, input, 1 bit: level-sensitive capture enable.
REQ-008 SHALL have port address_i, input, ADDR_WIDTH bits: FFT read address.
REQ-009 SHALL have port data_o, output, SAMPLE_WIDTH bits: read data for address_i.
REQ-010 SHALL have port start_o, output, 1 bit: one-cycle pulse when a full frame is ready for the FFT.
REQ-011 SHALL have port release_i, input, 1 bit: one-cycle pulse from the FFT side freeing the read bank.
REQ-012 SHALL have port overrun_o, output, 1 bit: sticky flag set when a frame is dropped.
REQ-013 SHALL have port overrun_cnt_o, output, 8 bits: count of dropped frames.

Function
REQ-014 SHALL hold two banks of 2^ADDR_WIDTH x SAMPLE_WIDTH storage; wbank selects the write bank, and the read bank is always ~wbank.
REQ-015 SHALL implement FSM states IDLE, FILL and HANDOFF.
REQ-016 IDLE -> FILL SHALL occur on the first cycle enable_i=1; in FILL, FSM SHALL return to IDLE when enable_i=0, clearing wr_ptr to 0 and discarding the partial frame.
REQ-017 In FILL, each cycle with sample_valid_i=1 SHALL write sample_i to bank[wbank][wr_ptr] and increment wr_ptr modulo 2^ADDR_WIDTH.
REQ-018 A write at wr_ptr = 2^ADDR_WIDTH-1 SHALL move the FSM to HANDOFF on the next cycle.
REQ-019 In HANDOFF with rd_busy=0: SHALL toggle wbank, set rd_busy=1, assert start_o for exactly one cycle, and return to FILL, all in that single cycle.
REQ-020 In HANDOFF with rd_busy=1: SHALL keep wbank, set overrun_o, increment the overrun counter, and return to FILL; the new frame overwrites the same bank from address 0, and start_o stays 0.
REQ-021 Samples with sample_valid_i=1 during HANDOFF SHALL be written at address 0 of the post-decision write bank, and wr_ptr SHALL become 1.
REQ-022 release_i SHALL clear rd_busy; if release_i and a HANDOFF decision fall in the same cycle, the release SHALL take effect first, so the handoff succeeds.
REQ-023 data_o SHALL equal bank[~wbank][address_i] sampled at the clk edge, giving 1-cycle registered read latency; reads are valid at any time, and after a bank toggle they return the new bank from the following edge.
REQ-024 The write bank and the read bank SHALL never be the same; no read-during-write hazard is permitted.
REQ-025 release_i with rd_busy=0 SHALL be ignored.

Reset
REQ-026 On rst_n=0, SHALL asynchronously set: state=IDLE, wr_ptr=0, wbank=0, rd_busy=0, start_o=0, data_o=0, overrun_o=0, overrun_cnt_o=0; memory contents are not reset.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release, no start_o SHALL occur until 1024 new samples have been captured.

Configuration
REQ-028 With macro SAMPLE_OVERRUN_CNT_EN defined, overrun_cnt_o SHALL be an 8-bit counter saturating at 255.
REQ-029 Without SAMPLE_OVERRUN_CNT_EN, overrun_cnt_o SHALL be constant 0 and no counter flops SHALL be synthesized; overrun_o SHALL be unaffected.

Verification
REQ-030 Reset, then enable_i=1, then 1024 valid samples with value k at index k -> one start_o pulse 1 cycle after the last write; reading address 5 -> data_o=5 one cycle later.
REQ-031 Second frame of 1024 samples with no release_i -> start_o stays 0, overrun_o=1, overrun_cnt_o=1; reading address 5 still returns 5.
REQ-032 release_i pulsed in the same cycle as HANDOFF for frame 3 -> start_o pulses, overrun_cnt_o is unchanged, and the bank toggles.
REQ-033 rst_n pulsed low after 500 samples -> all outputs 0; the next start_o occurs only after 1024 further samples.
REQ-034 enable_i dropped after 300 samples, then re-raised -> a full 1024 new samples are required before start_o.
REQ-035 300 consecutive overruns with SAMPLE_OVERRUN_CNT_EN defined -> overrun_cnt_o=255; the same stimulus without the macro -> overrun_cnt_o=0 and overrun_o=1.
